sd_req_arbiter: RTL and testbench
=================================

SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters / SD block-device slots (floppy, HDD0, HDD1).
REQ-002 Parameter TIMEOUT_CYCLES, default 24'd1_000_000, ack watchdog limit in clk_sys cycles.
REQ-003 clk_sys  in  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 req_rd  in  NUM_REQ  per-slot one-cycle read request pulse.
REQ-006 req_wr  in  NUM_REQ  per-slot one-cycle write request pulse.
REQ-007 req_lba  in  32*NUM_REQ  per-slot sector address, slot i at bits [32i+31:32i].
REQ-008 sd_ack  in  NUM_REQ  per-slot transfer acknowledge from the SD host.
REQ-009 sd_lba  out  32  sector address of the granted request.
REQ-010 sd_rd / sd_wr  out  NUM_REQ each  one-hot read/write strobes, bit = granted slot.
REQ-011 grant  out  NUM_REQ  one-hot granted slot, zero when idle.
REQ-012 req_done  out  NUM_REQ  one-cycle completion pulse per slot.
REQ-013 req_err  out  NUM_REQ  one-cycle timeout pulse per slot.
REQ-014 cpu_wait  out  1  CPU stall, high while any request is pending or in service.

Function
REQ-015 Each slot SHALL hold rd_pend, wr_pend and an LBA register; a req_rd/req_wr pulse sets the flag and captures req_lba of that slot in the same edge.
REQ-016 A set on a flag SHALL win over a clear of that flag in the same cycle.
REQ-017 FSM states SHALL be IDLE, ISSUE, XFER, DONE.
REQ-018 IDLE: if any flag pending, select the first pending slot searching round-robin from (last_grant+1) mod NUM_REQ, drive grant, sd_lba, and sd_rd (if rd_pend) else sd_wr; go ISSUE.
REQ-019 Latency: request pulse at edge N -> sd_rd/sd_wr high after edge N+2 when idle.
REQ-020 If a slot has both flags set, read SHALL be served first; write remains pending for a later grant.
REQ-021 ISSUE: on sd_ack[g] rising (registered previous value 0, current 1) clear the served flag, drop sd_rd/sd_wr; go XFER.
REQ-022 XFER: on sd_ack[g] falling go DONE; sd_lba and grant held stable throughout.
REQ-023 DONE: pulse req_done[g] one cycle, set last_grant=g, clear grant; return IDLE.
REQ-024 Ack on a non-granted slot SHALL be ignored.
REQ-025 New requests SHALL be accepted in every state, including for the slot in service; they are served on a later grant.
REQ-026 cpu_wait SHALL be registered: high the edge after any flag set, low only in the cycle after DONE when no flag is pending.
REQ-027 A repeat request on an already-pending flag SHALL overwrite the LBA register and remain a single request.

Reset
REQ-028 reset_n low SHALL asynchronously clear all flags, LBA registers, last_grant (to NUM_REQ-1), FSM to IDLE, and drive every output to 0.
REQ-029 Reset mid-transfer SHALL abandon the transfer without req_done or req_err; no request survives reset.

Configuration
REQ-030 Macro SD_ARB_TIMEOUT_EN defined: a counter runs in ISSUE and XFER; reaching TIMEOUT_CYCLES drops sd_rd/sd_wr, clears the served flag, pulses req_err[g] instead of req_done[g], and proceeds through DONE.
REQ-031 SD_ARB_TIMEOUT_EN undefined: no counter is implemented, the FSM waits indefinitely, and req_err is tied to 0.

Verification
REQ-032 Single read: req_rd[1] with lba 0x0000_0123; ack rises 5 cycles later, falls 20 later -> sd_rd=3'b010, sd_lba=0x123 two cycles after the request; req_done[1] one pulse; cpu_wait low afterwards.
REQ-033 Round-robin: req_rd on slots 0, 1, 2 in the same cycle -> grants in order 0, 1, 2; repeat after last_grant=0 -> order 1, 2, 0.
REQ-034 Both flags: req_rd[2] and req_wr[2] together -> sd_rd[2] transfer completes, then a separate sd_wr[2] transfer; two req_done[2] pulses.
REQ-035 Reset mid-op: assert reset_n low during XFER -> all outputs 0 immediately, no req_done, a later ack is ignored.
REQ-036 Timeout with SD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> sd_rd drops after 16 cycles, req_err pulses once, cpu_wait falls; without the macro sd_rd stays high.
REQ-037 Foreign ack: pulse sd_ack[0] while slot 1 is granted -> no state change.

Source files
------------

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter multiplexing per-slot SD sector read/write requests onto one SD host port.
// Optional ack watchdog enabled by defining SD_ARB_TIMEOUT_EN.
module sd_req_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_rd,
    input  logic [NUM_REQ-1:0]     req_wr,
    input  logic [32*NUM_REQ-1:0]  req_lba,
    input  logic [NUM_REQ-1:0]     sd_ack,
    output logic [31:0]            sd_lba,
    output logic [NUM_REQ-1:0]     sd_rd,
    output logic [NUM_REQ-1:0]     sd_wr,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_err,
    output logic                   cpu_wait
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] rd_pend_q, wr_pend_q, rd_pend_d, wr_pend_d;
    logic [NUM_REQ-1:0] rd_clr, wr_clr;
    logic [31:0]        lba_q [NUM_REQ];
    logic [IW-1:0]      last_q, g_q, sel;
    logic               sel_vld;
    logic [NUM_REQ-1:0] ack_q;
    logic               serve_rd_q;
    logic [31:0]        sd_lba_q;
    logic [NUM_REQ-1:0] sd_rd_q, sd_wr_q, grant_q, done_q;
    logic               cpu_wait_q;
    logic               ack_rise, ack_fall, timeout;

    assign ack_rise = sd_ack[g_q] & ~ack_q[g_q];
    assign ack_fall = ~sd_ack[g_q] & ack_q[g_q];

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0]        tmr_q;
    logic [NUM_REQ-1:0] err_q;
    assign timeout = ((state_q == ISSUE) || (state_q == XFER)) && (tmr_q == TIMEOUT_CYCLES - 24'd1);
    assign req_err = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
    assign req_err = '0;
`endif

    // First pending slot, searching upward from the one after last_grant with wrap.
    always_comb begin
        int unsigned   idx;
        logic [IW-1:0] cand;
        idx     = 0;
        cand    = '0;
        sel     = '0;
        sel_vld = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = 32'(last_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = IW'(idx);
            if (!sel_vld && (rd_pend_q[cand] || wr_pend_q[cand])) begin
                sel_vld = 1'b1;
                sel     = cand;
            end
        end
    end

    // The served flag is released on ack rise (or watchdog expiry) while issuing; sets override.
    always_comb begin
        rd_clr = '0;
        wr_clr = '0;
        if ((state_q == ISSUE) && (ack_rise || timeout)) begin
            if (serve_rd_q) rd_clr[g_q] = 1'b1;
            else            wr_clr[g_q] = 1'b1;
        end
        rd_pend_d = (rd_pend_q & ~rd_clr) | req_rd;
        wr_pend_d = (wr_pend_q & ~wr_clr) | req_wr;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rd_pend_q  <= '0;
            wr_pend_q  <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) lba_q[i] <= '0;
            last_q     <= IW'(NUM_REQ - 1);
            g_q        <= '0;
            ack_q      <= '0;
            serve_rd_q <= 1'b0;
            sd_lba_q   <= '0;
            sd_rd_q    <= '0;
            sd_wr_q    <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            cpu_wait_q <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
            tmr_q      <= '0;
            err_q      <= '0;
`endif
        end else begin
            rd_pend_q  <= rd_pend_d;
            wr_pend_q  <= wr_pend_d;
            ack_q      <= sd_ack;
            cpu_wait_q <= cpu_wait_q | (|(req_rd | req_wr));
            for (int unsigned i = 0; i < NUM_REQ; i++)
                if (req_rd[i] || req_wr[i]) lba_q[i] <= req_lba[32*i +: 32];
`ifdef SD_ARB_TIMEOUT_EN
            tmr_q <= (state_q == IDLE) ? '0 : tmr_q + 24'd1;
`endif
            case (state_q)
                IDLE: begin
                    if (sel_vld) begin
                        g_q        <= sel;
                        grant_q    <= ONE << sel;
                        sd_lba_q   <= lba_q[sel];
                        serve_rd_q <= rd_pend_q[sel];
                        if (rd_pend_q[sel]) sd_rd_q <= ONE << sel;
                        else                sd_wr_q <= ONE << sel;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ack_rise) begin
                        sd_rd_q <= '0;
                        sd_wr_q <= '0;
                        state_q <= XFER;
                    end
`ifdef SD_ARB_TIMEOUT_EN
                    else if (timeout) begin
                        sd_rd_q <= '0;
                        sd_wr_q <= '0;
                        err_q   <= grant_q;
                        state_q <= DONE;
                    end
`endif
                end
                XFER: begin
                    if (ack_fall) begin
                        done_q  <= grant_q;
                        state_q <= DONE;
                    end
`ifdef SD_ARB_TIMEOUT_EN
                    else if (timeout) begin
                        err_q   <= grant_q;
                        state_q <= DONE;
                    end
`endif
                end
                DONE: begin
                    done_q     <= '0;
                    grant_q    <= '0;
                    last_q     <= g_q;
                    cpu_wait_q <= |(rd_pend_d | wr_pend_d);
`ifdef SD_ARB_TIMEOUT_EN
                    err_q      <= '0;
`endif
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sd_lba   = sd_lba_q;
    assign sd_rd    = sd_rd_q;
    assign sd_wr    = sd_wr_q;
    assign grant    = grant_q;
    assign req_done = done_q;
    assign cpu_wait = cpu_wait_q;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed self-checking bench for sd_req_arbiter (3 slots, watchdog limit 16 when enabled).
module tb_sd_req_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  req_rd  = '0;
    logic [2:0]  req_wr  = '0;
    logic [95:0] req_lba = '0;
    logic [2:0]  sd_ack  = '0;
    logic [31:0] sd_lba;
    logic [2:0]  sd_rd, sd_wr, grant, req_done, req_err;
    logic        cpu_wait;

    int checks   = 0;
    int failures = 0;

    sd_req_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(24'd16)) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .req_rd   (req_rd),
        .req_wr   (req_wr),
        .req_lba  (req_lba),
        .sd_ack   (sd_ack),
        .sd_lba   (sd_lba),
        .sd_rd    (sd_rd),
        .sd_wr    (sd_wr),
        .grant    (grant),
        .req_done (req_done),
        .req_err  (req_err),
        .cpu_wait (cpu_wait)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] oh(input int s);
        return 3'(1 << s);
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_rd  = '0;
        req_wr  = '0;
        sd_ack  = '0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic req(input logic [2:0] rd, input logic [2:0] wr, input logic [95:0] lba);
        req_rd  = rd;
        req_wr  = wr;
        req_lba = lba;
        tick();
        req_rd  = '0;
        req_wr  = '0;
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        while ((sd_rd | sd_wr) == 3'b000 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 20), 32'd1);
    endtask

    // Expects the given slot to be granted next, completes its handshake and checks the done pulse.
    task automatic serve(input int slot, input bit is_rd, input logic [31:0] lba);
        int n = 0;
        wait_strobe("strobe_seen");
        check("grant", 32'(grant), 32'(oh(slot)));
        check(is_rd ? "sd_rd" : "sd_wr", 32'(is_rd ? sd_rd : sd_wr), 32'(oh(slot)));
        check(is_rd ? "sd_wr_idle" : "sd_rd_idle", 32'(is_rd ? sd_wr : sd_rd), 32'd0);
        check("sd_lba", sd_lba, lba);
        sd_ack[slot] = 1'b1;
        tick();
        check("strobe_drop", 32'(sd_rd | sd_wr), 32'd0);
        tick();
        sd_ack[slot] = 1'b0;
        while (req_done == 3'b000 && n < 10) begin
            tick();
            n++;
        end
        check("req_done", 32'(req_done), 32'(oh(slot)));
        tick();
        check("done_once", 32'(req_done), 32'd0);
    endtask

    initial begin
        do_reset();
        check("rst_outputs", {26'd0, grant, sd_rd}, 32'd0);
        check("rst_misc", {26'd0, req_done, sd_wr} | {31'd0, cpu_wait}, 32'd0);
        check("rst_lba", sd_lba, 32'd0);

        // Single read with 2-cycle latency, ack rising 5 cycles later and falling 20 after that
        req(3'b010, 3'b000, {32'd0, 32'h0000_0123, 32'd0});
        check("lat_early", 32'(sd_rd), 32'd0);
        tick();
        check("lat_sd_rd", 32'(sd_rd), 32'h2);
        check("lat_sd_lba", sd_lba, 32'h123);
        check("lat_wait", 32'(cpu_wait), 32'd1);
        repeat (4) tick();
        sd_ack[1] = 1'b1;
        tick();
        check("single_drop", 32'(sd_rd), 32'd0);
        check("single_grant", 32'(grant), 32'h2);
        repeat (19) tick();
        check("single_nodone", 32'(req_done), 32'd0);
        sd_ack[1] = 1'b0;
        tick();
        check("single_done", 32'(req_done), 32'h2);
        tick();
        check("single_done_end", 32'(req_done), 32'd0);
        check("single_grant_end", 32'(grant), 32'd0);
        check("single_wait_low", 32'(cpu_wait), 32'd0);

        // Round robin from reset, then after last_grant = 0
        do_reset();
        req(3'b111, 3'b000, {32'hA2, 32'hA1, 32'hA0});
        serve(0, 1, 32'hA0);
        serve(1, 1, 32'hA1);
        serve(2, 1, 32'hA2);
        req(3'b001, 3'b000, {32'hA2, 32'hA1, 32'hB0});
        serve(0, 1, 32'hB0);
        req(3'b111, 3'b000, {32'hC2, 32'hC1, 32'hC0});
        serve(1, 1, 32'hC1);
        serve(2, 1, 32'hC2);
        serve(0, 1, 32'hC0);
        check("rr_wait_low", 32'(cpu_wait), 32'd0);

        // Read and write on the same slot: read first, then a separate write
        req(3'b100, 3'b100, {32'h77, 32'd0, 32'd0});
        serve(2, 1, 32'h77);
        serve(2, 0, 32'h77);
        check("both_wait_low", 32'(cpu_wait), 32'd0);

        // Foreign ack on slot 0 while slot 1 is granted
        req(3'b010, 3'b000, {32'd0, 32'h42, 32'd0});
        wait_strobe("foreign_strobe");
        sd_ack[0] = 1'b1;
        repeat (2) tick();
        sd_ack[0] = 1'b0;
        repeat (2) tick();
        check("foreign_sd_rd", 32'(sd_rd), 32'h2);
        check("foreign_grant", 32'(grant), 32'h2);
        check("foreign_nodone", 32'(req_done), 32'd0);
        serve(1, 1, 32'h42);

        // Requests during service: repeated read on slot 0 merges, write on in-service slot 1 queues
        req(3'b010, 3'b000, {32'd0, 32'h31, 32'd0});
        tick();
        req(3'b001, 3'b010, {32'd0, 32'h99, 32'h10});
        req(3'b001, 3'b000, {32'd0, 32'h99, 32'h20});
        serve(1, 1, 32'h31);
        serve(0, 1, 32'h20);
        serve(1, 0, 32'h99);
        repeat (4) tick();
        check("merge_no_extra", 32'(grant | sd_rd | sd_wr), 32'd0);
        check("merge_wait_low", 32'(cpu_wait), 32'd0);

        // Reset in the middle of a transfer
        req(3'b001, 3'b000, {32'd0, 32'd0, 32'h55});
        wait_strobe("rst_strobe");
        sd_ack[0] = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        check("rstmid_grant", 32'(grant), 32'd0);
        check("rstmid_lba", sd_lba, 32'd0);
        check("rstmid_wait", 32'(cpu_wait), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        sd_ack[0] = 1'b0;
        repeat (4) tick();
        check("rstmid_nodone", 32'(req_done | req_err), 32'd0);
        check("rstmid_idle", 32'(grant | sd_rd | sd_wr), 32'd0);

        // No ack at all: watchdog expiry if enabled, otherwise the strobe is held
        req(3'b100, 3'b000, {32'h3C, 32'd0, 32'd0});
        wait_strobe("to_strobe");
`ifdef SD_ARB_TIMEOUT_EN
        begin
            int n = 0;
            while (sd_rd != 3'b000 && n < 40) begin
                tick();
                n++;
            end
            check("to_cycles", 32'(n), 32'd16);
            check("to_err", 32'(req_err), 32'h4);
            check("to_nodone", 32'(req_done), 32'd0);
            tick();
            check("to_err_once", 32'(req_err), 32'd0);
            check("to_wait_low", 32'(cpu_wait), 32'd0);
        end
`else
        repeat (40) tick();
        check("noto_sd_rd", 32'(sd_rd), 32'h4);
        check("noto_err", 32'(req_err), 32'd0);
        serve(2, 1, 32'h3C);
        check("noto_wait_low", 32'(cpu_wait), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
